// File: rtl/lz77_decoder_stream.sv
// rtl/lz77_decoder_stream.sv - streaming LZ77 codeword decoder with sliding search window
module lz77_decoder_stream #(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 9,
  parameter int                POS_W     = 4,
  parameter int                LEN_W     = 3,
  parameter logic [DATA_W-1:0] TERM_CHAR = 8'h24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POS_W-1:0]  code_pos,
  input  logic [LEN_W-1:0]  code_len,
  input  logic [DATA_W-1:0] chardata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] char_nxt,
  output logic              finish,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_LIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]  lit_q, lit_d;
  logic [DATA_W-1:0]  char_q, char_d;
  logic               out_valid_q, out_valid_d;
  logic               finish_q, finish_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  win_q [DEPTH];
  logic [DATA_W-1:0]  win_d [DEPTH];

  logic               slot_free;
  logic               in_ready_c;
  logic               accept;
  logic               emit;
  logic [DATA_W-1:0]  emit_char;
  logic [DATA_W-1:0]  copy_char;
  logic               pos_illegal;

  // The output register can take a new character when empty or being drained
  assign slot_free   = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready_c;
  assign pos_illegal = (32'(code_pos) >= 32'(DEPTH)) && (code_len != '0);

  assign in_ready  = reset && in_ready_c;
  assign out_valid = out_valid_q;
  assign char_nxt  = char_q;
  assign finish    = finish_q;
  assign err       = err_q;

  // Window lookup; an out-of-range position matches no entry and reads as zero
  always_comb begin
    copy_char = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pos_q == POS_W'(i)) copy_char = win_q[i];
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      rem_q       <= '0;
      lit_q       <= '0;
      char_q      <= '0;
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      rem_q       <= rem_d;
      lit_q       <= lit_d;
      char_q      <= char_d;
      out_valid_q <= out_valid_d;
      finish_q    <= finish_d;
      err_q       <= err_d;
      win_q       <= win_d;
    end
  end

  // Next-state: copy runs until its last character, literal chains straight into the next codeword
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = (code_len != '0) ? S_COPY : S_LIT;
      end
      S_COPY: begin
        if (slot_free && rem_q == LEN_W'(1)) state_d = S_LIT;
      end
      S_LIT: begin
        if (slot_free) begin
          if (lit_q == TERM_CHAR) state_d = S_DONE;
          else if (in_valid)      state_d = (code_len != '0) ? S_COPY : S_LIT;
          else                    state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath: handshake, emission, window shift, sticky flags
  always_comb begin
    in_ready_c = 1'b0;
    emit       = 1'b0;
    emit_char  = '0;
    case (state_q)
      S_IDLE: in_ready_c = 1'b1;
      S_COPY: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_char = copy_char;
        end
      end
      S_LIT: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_char = lit_q;
          if (lit_q != TERM_CHAR) in_ready_c = 1'b1;
        end
      end
      default: in_ready_c = 1'b0;
    endcase

    pos_d = accept ? code_pos : pos_q;
    lit_d = accept ? chardata : lit_q;
    if (accept)                                 rem_d = code_len;
    else if (state_q == S_COPY && slot_free)    rem_d = rem_q - LEN_W'(1);
    else                                        rem_d = rem_q;

    // Illegal copies still run; their characters come out as zero from the lookup
    err_d    = err_q | (accept && pos_illegal);
    finish_d = finish_q |
               (state_q == S_DONE && out_valid_q && out_ready && char_q == TERM_CHAR);

    char_d      = emit ? emit_char : char_q;
    out_valid_d = emit ? 1'b1 : (slot_free ? 1'b0 : out_valid_q);

    win_d = win_q;
    if (emit) begin
      win_d[0] = emit_char;
      for (int i = 0; i < DEPTH - 1; i++) win_d[i+1] = win_q[i];
    end
  end

endmodule

// File: tb/tb_lz77_decoder_stream.sv
// tb/tb_lz77_decoder_stream.sv - directed self-checking bench for lz77_decoder_stream
module tb_lz77_decoder_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] code_pos;
  logic [2:0] code_len;
  logic [7:0] chardata;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] char_nxt;
  logic       finish;
  logic       err;

  logic       in2_valid;
  logic       in2_ready;
  logic [3:0] pos2;
  logic [2:0] len2;
  logic [7:0] lit2;
  logic       out2_valid;
  logic [7:0] char2;
  logic       finish2;
  logic       err2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] oq [$];
  int         ocyc [$];
  logic [7:0] oq2 [$];

  always #5 clk = ~clk;

  lz77_decoder_stream #(.DATA_W(8), .DEPTH(9), .POS_W(4), .LEN_W(3), .TERM_CHAR(8'h24)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .code_pos(code_pos), .code_len(code_len), .chardata(chardata),
    .out_valid(out_valid), .out_ready(out_ready), .char_nxt(char_nxt),
    .finish(finish), .err(err)
  );

  lz77_decoder_stream #(.DATA_W(8), .DEPTH(16), .POS_W(4), .LEN_W(3), .TERM_CHAR(8'h24)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in2_valid), .in_ready(in2_ready),
    .code_pos(pos2), .code_len(len2), .chardata(lit2),
    .out_valid(out2_valid), .out_ready(1'b1), .char_nxt(char2),
    .finish(finish2), .err(err2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake that will complete on the coming rising edge
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      oq.push_back(char_nxt);
      ocyc.push_back(cyc);
    end
    if (reset && out2_valid) oq2.push_back(char2);
  end

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in2_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic send(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
    int n = 0;
    code_pos = p;
    code_len = l;
    chardata = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout pos=%0d len=%0d lit=%02h in_ready stayed 0", p, l, c);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int need);
    int k = 0;
    while (oq.size() < need && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (oq.size() < need) begin
      checks++;
      errors++;
      $display("FAIL wait_out got=%0d need=%0d", oq.size(), need);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in2_valid = 1'b0;
    out_ready = 1'b1;
    code_pos  = '0;
    code_len  = '0;
    chardata  = '0;
    pos2      = '0;
    len2      = '0;
    lit2      = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready  !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (char_nxt  !== 8'h00) begin errors++; $display("FAIL reset_char_nxt got=%02h exp=00", char_nxt); end
    checks++; if (finish    !== 1'b0)  begin errors++; $display("FAIL reset_finish got=%b exp=0", finish); end
    checks++; if (err       !== 1'b0)  begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready  !== 1'b1)  begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_literal_chain();
    string exp_s = "ababac$";
    int base;
    int acc;
    int seen;
    do_reset();
    base = oq.size();
    send(4'd0, 3'd0, "a");
    acc = cyc;
    send(4'd0, 3'd0, "b");
    send(4'd1, 3'd3, "c");
    send(4'd0, 3'd0, "$");
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL chain_finish_early got=%b exp=0", finish); end
    wait_out(base + 7);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (base + i >= oq.size() || oq[base+i] !== exp_s[i]) begin
        errors++;
        $display("FAIL chain_char[%0d] got=%02h exp=%02h", i, (base + i < oq.size()) ? oq[base+i] : 8'hxx, exp_s[i]);
      end
    end
    if (oq.size() >= base + 7) begin
      checks++;
      if (ocyc[base] !== acc + 1) begin errors++; $display("FAIL chain_latency got=%0d exp=%0d", ocyc[base] - acc, 1); end
      checks++;
      if (ocyc[base+6] - ocyc[base] !== 6) begin errors++; $display("FAIL chain_throughput span=%0d exp=6", ocyc[base+6] - ocyc[base]); end
    end
    checks++; if (finish    !== 1'b1) begin errors++; $display("FAIL chain_finish got=%b exp=1", finish); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL chain_out_valid_after got=%b exp=0", out_valid); end
    checks++; if (in_ready  !== 1'b0) begin errors++; $display("FAIL chain_in_ready_done got=%b exp=0", in_ready); end
    seen = oq.size();
    code_pos = 4'd0; code_len = 3'd0; chardata = "k"; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (oq.size() !== seen || finish !== 1'b1) begin errors++; $display("FAIL done_ignores got_outputs=%0d exp=%0d finish=%b", oq.size() - seen, 0, finish); end
  endtask

  task automatic test_self_overlap();
    string exp_s = "xxxxxy";
    int base;
    do_reset();
    base = oq.size();
    send(4'd0, 3'd0, "x");
    send(4'd0, 3'd4, "y");
    wait_out(base + 6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (base + i >= oq.size() || oq[base+i] !== exp_s[i]) begin
        errors++;
        $display("FAIL overlap_char[%0d] got=%02h exp=%02h", i, (base + i < oq.size()) ? oq[base+i] : 8'hxx, exp_s[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    string exp_s = "abcabcabd";
    logic [7:0] run0 [9];
    logic [7:0] held;
    int base;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      base = oq.size();
      send(4'd0, 3'd0, "a");
      send(4'd0, 3'd0, "b");
      send(4'd0, 3'd0, "c");
      send(4'd2, 3'd5, "d");
      if (r == 1) begin
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = char_nxt;
        checks++; if (held !== "a") begin errors++; $display("FAIL stall_first_copy got=%02h exp=%02h", held, 8'h61); end
        for (int s = 0; s < 3; s++) begin
          @(posedge clk);
          #1;
          checks++;
          if (char_nxt !== held || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold[%0d] got=%02h/%b exp=%02h/1", s, char_nxt, out_valid, held);
          end
        end
        out_ready = 1'b1;
      end
      wait_out(base + 9);
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (base + i >= oq.size() || oq[base+i] !== exp_s[i]) begin
          errors++;
          $display("FAIL bp_run%0d_char[%0d] got=%02h exp=%02h", r, i, (base + i < oq.size()) ? oq[base+i] : 8'hxx, exp_s[i]);
        end
        if (base + i < oq.size()) begin
          if (r == 0) run0[i] = oq[base+i];
          else begin
            checks++;
            if (oq[base+i] !== run0[i]) begin errors++; $display("FAIL bp_vs_unstalled[%0d] got=%02h exp=%02h", i, oq[base+i], run0[i]); end
          end
        end
      end
    end
  endtask

  task automatic test_window_depth();
    int base;
    int base2;
    int k;
    int not_ready;
    do_reset();
    base = oq.size();
    for (int i = 1; i <= 9; i++) send(4'd0, 3'd0, 8'(i));
    send(4'd8, 3'd1, 8'h00);
    wait_out(base + 11);
    if (oq.size() >= base + 11) begin
      checks++; if (oq[base+8]  !== 8'd9) begin errors++; $display("FAIL depth9_last_lit got=%02h exp=09", oq[base+8]); end
      checks++; if (oq[base+9]  !== 8'd1) begin errors++; $display("FAIL depth9_oldest got=%02h exp=01", oq[base+9]); end
      checks++; if (oq[base+10] !== 8'd0) begin errors++; $display("FAIL depth9_lit got=%02h exp=00", oq[base+10]); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL depth9_err got=%b exp=0", err); end

    base2 = oq2.size();
    not_ready = 0;
    in2_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      pos2 = (i == 17) ? 4'd15 : 4'd0;
      len2 = (i == 17) ? 3'd1  : 3'd0;
      lit2 = (i == 17) ? 8'h00 : 8'(i);
      @(negedge clk);
      if (!in2_ready) not_ready++;
      @(posedge clk);
      #1;
    end
    in2_valid = 1'b0;
    checks++; if (not_ready !== 0) begin errors++; $display("FAIL depth16_accept stalls=%0d exp=0", not_ready); end
    k = 0;
    while (oq2.size() < base2 + 18 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (oq2.size() < base2 + 18) begin
      errors++;
      $display("FAIL depth16_count got=%0d exp=18", oq2.size() - base2);
    end else begin
      if (oq2[base2+15] !== 8'd16 || oq2[base2+16] !== 8'd1 || oq2[base2+17] !== 8'd0) begin
        errors++;
        $display("FAIL depth16_copy got=%02h,%02h,%02h exp=10,01,00", oq2[base2+15], oq2[base2+16], oq2[base2+17]);
      end
    end
    checks++; if (err2 !== 1'b0 || finish2 !== 1'b0) begin errors++; $display("FAIL depth16_flags got=%b%b exp=00", err2, finish2); end
  endtask

  task automatic test_illegal_pos();
    int base;
    do_reset();
    base = oq.size();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_before got=%b exp=0", err); end
    send(4'd12, 3'd2, "z");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err_on_accept got=%b exp=1", err); end
    wait_out(base + 3);
    if (oq.size() >= base + 3) begin
      checks++;
      if (oq[base] !== 8'h00 || oq[base+1] !== 8'h00 || oq[base+2] !== "z") begin
        errors++;
        $display("FAIL illegal_output got=%02h,%02h,%02h exp=00,00,7a", oq[base], oq[base+1], oq[base+2]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_mid_copy_reset();
    int base;
    do_reset();
    send(4'd0, 3'd0, "a");
    send(4'd0, 3'd0, "b");
    send(4'd0, 3'd0, "c");
    send(4'd0, 3'd0, "d");
    send(4'd12, 3'd5, "e");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL midreset_err_set got=%b exp=1", err); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    checks++; if (err       !== 1'b0) begin errors++; $display("FAIL midreset_err got=%b exp=0", err); end
    checks++; if (finish    !== 1'b0) begin errors++; $display("FAIL midreset_finish got=%b exp=0", finish); end
    checks++; if (char_nxt  !== 8'h00) begin errors++; $display("FAIL midreset_char got=%02h exp=00", char_nxt); end
    reset = 1'b1;
    base = oq.size();
    send(4'd3, 3'd2, "q");
    wait_out(base + 3);
    if (oq.size() >= base + 3) begin
      checks++;
      if (oq[base] !== 8'h00 || oq[base+1] !== 8'h00 || oq[base+2] !== "q") begin
        errors++;
        $display("FAIL midreset_window got=%02h,%02h,%02h exp=00,00,71", oq[base], oq[base+1], oq[base+2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_literal_chain();
    test_self_overlap();
    test_backpressure();
    test_window_depth();
    test_illegal_pos();
    test_mid_copy_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lz77_decoder_stream.md
Name: lz77_decoder_stream

Overview:
- Parametrised next-generation LZ77 decoder: takes (position, length, literal) codewords over a valid/ready input handshake and emits decoded characters over a valid/ready output handshake.
- Keeps a configurable-depth sliding search window, supports self-overlapping copies and output backpressure, and flags illegal codewords.
- Signals completion when the terminator literal has been delivered.
- Sits between the codeword source (testbench or unpacker) and the character sink.

Parameters:
- DATA_W, 8: character width in bits.
- DEPTH, 9: search window depth in characters; legal positions are 0..DEPTH-1.
- POS_W, 4: code_pos width; must satisfy 2^POS_W >= DEPTH.
- LEN_W, 3: code_len width; maximum copy length is 2^LEN_W-1.
- TERM_CHAR, 8'h24: literal that ends the stream ('$').

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
- in_valid  in  1  codeword present
- in_ready  out  1  decoder accepts a codeword this cycle
- code_pos  in  POS_W  copy source: window index, 0 = most recent character
- code_len  in  LEN_W  number of characters to copy; 0 means literal only
- chardata  in  DATA_W  literal emitted after the copy
- out_valid  out  1  char_nxt holds a valid decoded character
- out_ready  in  1  sink accepts char_nxt
- char_nxt  out  DATA_W  decoded character
- finish  out  1  terminator delivered; sticky until reset
- err  out  1  sticky illegal-codeword flag

Behaviour:
- Reset (reset==0 at a clock edge) clears the following, regardless of any operation in progress: in_ready=0, out_valid=0, char_nxt=0, finish=0, err=0, all window entries=0, state=IDLE.
- Terms:
  - Slot free = !out_valid || out_ready.
  - Emit X = on a slot-free edge: char_nxt<=X, out_valid<=1, win[0]<=X, win[i+1]<=win[i] for i=0..DEPTH-2 (oldest entry dropped).
  - If the slot is not free, state, window and char_nxt all hold.
  - If the slot is free and nothing is emitted, out_valid<=0.
- States:
  - IDLE:
    - in_ready=1.
    - On handshake, latch pos, len, lit; rem<=len.
    - Go to COPY if len!=0, else to LIT.
    - No emission in the accept cycle.
  - COPY:
    - Each slot-free edge: emit win[pos_latched], rem<=rem-1.
    - When rem==1 at that edge, go to LIT.
    - pos is relative to the current, shifting window, so pos < len repeats the pattern (self-overlap).
  - LIT:
    - On a slot-free edge: emit lit.
    - If lit==TERM_CHAR, go to DONE. Otherwise, if in_valid, accept the next codeword in the same cycle (in_ready=1 in LIT when the slot is free) and go to COPY or LIT; else go to IDLE.
  - DONE:
    - in_ready=0; further codewords are ignored.
    - finish<=1 on the edge where the terminator is handshaken out (out_valid && out_ready && char_nxt==TERM_CHAR).
    - out_valid clears after that handshake.
- in_ready is combinational from state and slot-free; it must not depend on in_valid.
- Throughput: with out_ready held at 1 and back-to-back codewords, one character per cycle after the first accept. Latency from first accept to first out_valid is 1 cycle.
- Illegal codeword: code_pos >= DEPTH with code_len != 0. Then err<=1 on accept; the copy still runs, but each copied character is forced to 0.
- TERM_CHAR inside a copy does not finish; only the literal does.
- finish rises one edge after the terminator handshake completes.

Test Plan:
- Literal chain: (0,0,'a'),(0,0,'b'),(1,3,'c'),(0,0,'$') with out_ready=1 -> char_nxt sequence "ababac$", one per cycle; finish=1 on the edge after '$' is handshaken; in_ready=0 afterwards.
- Self-overlap: after 'x', codeword (0,4,'y') -> "xxxxy".
- Backpressure: hold out_ready=0 for 3 cycles mid-copy -> char_nxt and the window are frozen, no character is lost or duplicated, and the resumed sequence is identical to the unstalled run.
- Window depth: with DEPTH=9, emit literals 1..9, then (8,1,0) -> copied character 1. Run again with parameter DEPTH=16 using position 15.
- Illegal position: (12,2,'z') with DEPTH=9 -> err=1 (sticky), output 0,0,'z'.
- Mid-copy reset: drive reset=0 during COPY -> next edge out_valid=0, finish=0, err=0, window zeroed. A following (3,2,'q') outputs 0,0,'q'.
